// File: rtl/inst_loadalign.sv
// Load alignment unit: issues word reads to the data SRAM, merges two words for
// loads that cross a word boundary, and returns a shifted/extended register write.
module inst_loadalign (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_op,
  input  logic [4:0]  ld_regindex,
  input  logic        ld_kill,
  input  logic [31:0] dsram_rdata,
  output logic        dsram_rcs,
  output logic [31:0] dsram_raddr,
  output logic        ld_wr_reg,
  output logic [4:0]  ld_wr_regindex,
  output logic [31:0] ld_wr_wdata,
  output logic        load_stall,
  output logic        load_misaligned_exxeption
);

  typedef enum logic [1:0] {IDLE, RD1, RD2} state_t;

  state_t      state_q, state_d;
  logic [29:0] waddr_q, waddr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] hold_q, hold_d;

  logic        cross_q, can_acc, wr;
  logic [31:0] raw;
  logic [63:0] merged;

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] v);
    case (op)
      3'b000:  extend = {{24{v[7]}}, v[7:0]};
      3'b001:  extend = {{16{v[15]}}, v[15:0]};
      3'b100:  extend = {24'h0, v[7:0]};
      3'b101:  extend = {16'h0, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  // Bytes never cross; halves cross only at offset 3; words cross at any nonzero offset.
  always_comb begin
    case (op_q)
      3'b000, 3'b100: cross_q = 1'b0;
      3'b001, 3'b101: cross_q = (off_q == 2'd3);
      default:        cross_q = (off_q != 2'd0);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    off_d       = off_q;
    op_d        = op_q;
    rd_d        = rd_q;
    hold_d      = hold_q;
    dsram_rcs   = 1'b0;
    dsram_raddr = {ld_addr[31:2], 2'b00};
    wr          = 1'b0;
    load_stall  = 1'b0;
    load_misaligned_exxeption = 1'b0;
    can_acc     = 1'b0;
    merged      = {dsram_rdata, hold_q} >> {off_q, 3'b000};
    raw         = merged[31:0];

    case (state_q)
      IDLE: can_acc = 1'b1;
      RD1: begin
        if (cross_q) begin
          hold_d      = dsram_rdata;
          dsram_rcs   = 1'b1;
          dsram_raddr = {waddr_q + 30'd1, 2'b00};
          load_stall  = 1'b1;
          load_misaligned_exxeption = 1'b1;
          state_d     = RD2;
        end else begin
          raw     = dsram_rdata >> {off_q, 3'b000};
          wr      = 1'b1;
          can_acc = 1'b1;
        end
      end
      RD2: begin
        wr      = 1'b1;
        can_acc = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (can_acc) begin
      if (ld_req && !ld_kill) begin
        dsram_rcs = 1'b1;
        waddr_d   = ld_addr[31:2];
        off_d     = ld_addr[1:0];
        op_d      = ld_op;
        rd_d      = ld_regindex;
        state_d   = RD1;
      end else begin
        state_d   = IDLE;
      end
    end

    if (ld_kill) begin
      wr         = 1'b0;
      dsram_rcs  = 1'b0;
      load_stall = 1'b0;
      load_misaligned_exxeption = 1'b0;
      state_d    = IDLE;
    end

    if (cpurst) begin
      wr         = 1'b0;
      dsram_rcs  = 1'b0;
      load_stall = 1'b0;
      load_misaligned_exxeption = 1'b0;
    end
  end

  assign ld_wr_reg      = wr;
  assign ld_wr_wdata    = wr ? extend(op_q, raw) : 32'h0;
  assign ld_wr_regindex = cpurst ? 5'd0 : rd_q;

  always_ff @(posedge clk) begin
    if (cpurst) begin
      state_q <= IDLE;
      waddr_q <= 30'h0;
      off_q   <= 2'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_inst_loadalign.sv
// Directed bench for inst_loadalign with a small synchronous SRAM model.
module tb_inst_loadalign;
  logic        clk = 1'b0;
  logic        cpurst, ld_req, ld_kill;
  logic [31:0] ld_addr, dsram_rdata, dsram_raddr, ld_wr_wdata;
  logic [2:0]  ld_op;
  logic [4:0]  ld_regindex, ld_wr_regindex;
  logic        dsram_rcs, ld_wr_reg, load_stall, load_misaligned_exxeption;

  int n_tests = 0;
  int n_fail  = 0;

  inst_loadalign dut (
    .clk(clk), .cpurst(cpurst), .ld_req(ld_req), .ld_addr(ld_addr), .ld_op(ld_op),
    .ld_regindex(ld_regindex), .ld_kill(ld_kill), .dsram_rdata(dsram_rdata),
    .dsram_rcs(dsram_rcs), .dsram_raddr(dsram_raddr), .ld_wr_reg(ld_wr_reg),
    .ld_wr_regindex(ld_wr_regindex), .ld_wr_wdata(ld_wr_wdata), .load_stall(load_stall),
    .load_misaligned_exxeption(load_misaligned_exxeption)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem = 32'h4433_2211;
      32'h0000_0104: mem = 32'h8877_6655;
      32'hFFFF_FFFC: mem = 32'hDDCC_BBAA;
      32'h0000_0000: mem = 32'h0302_0100;
      default:       mem = 32'hDEAD_BEEF;
    endcase
  endfunction

  initial dsram_rdata = 32'h0;
  always @(posedge clk) if (dsram_rcs) dsram_rdata <= mem(dsram_raddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [4:0] rd);
    ld_req = 1'b1; ld_op = op; ld_addr = a; ld_regindex = rd;
  endtask

  task automatic noreq();
    ld_req = 1'b0; ld_op = 3'b000; ld_addr = 32'h0; ld_regindex = 5'd0;
  endtask

  initial begin
    cpurst = 1'b1; ld_kill = 1'b0; noreq();
    step(); step(); #1;
    chk("rst_rcs", {31'h0, dsram_rcs}, 32'd0);
    chk("rst_wr", {31'h0, ld_wr_reg}, 32'd0);
    chk("rst_stall", {31'h0, load_stall}, 32'd0);
    chk("rst_mis", {31'h0, load_misaligned_exxeption}, 32'd0);
    chk("rst_wdata", ld_wr_wdata, 32'h0);
    chk("rst_rdidx", {27'h0, ld_wr_regindex}, 32'd0);

    // LB 0x107 then LBU 0x107 back-to-back
    step(); cpurst = 1'b0;
    req(3'b000, 32'h107, 5'd1); #1;
    chk("lb_rcs", {31'h0, dsram_rcs}, 32'd1);
    chk("lb_raddr", dsram_raddr, 32'h104);
    chk("lb_stall0", {31'h0, load_stall}, 32'd0);
    step(); req(3'b100, 32'h107, 5'd2); #1;
    chk("lb_wr", {31'h0, ld_wr_reg}, 32'd1);
    chk("lb_wdata", ld_wr_wdata, 32'hFFFF_FF88);
    chk("lb_rd", {27'h0, ld_wr_regindex}, 32'd1);
    chk("lb_stall1", {31'h0, load_stall}, 32'd0);
    chk("lbu_rcs", {31'h0, dsram_rcs}, 32'd1);
    step(); noreq(); #1;
    chk("lbu_wdata", ld_wr_wdata, 32'h0000_0088);
    chk("lbu_rd", {27'h0, ld_wr_regindex}, 32'd2);
    chk("lbu_stall", {31'h0, load_stall}, 32'd0);
    step(); #1;
    chk("idle_wr", {31'h0, ld_wr_reg}, 32'd0);

    // LW 0x102, rd=5 (crossing)
    req(3'b010, 32'h102, 5'd5); #1;
    chk("lw_raddr1", dsram_raddr, 32'h100);
    step(); noreq(); #1;
    chk("lw_raddr2", dsram_raddr, 32'h104);
    chk("lw_rcs2", {31'h0, dsram_rcs}, 32'd1);
    chk("lw_stall", {31'h0, load_stall}, 32'd1);
    chk("lw_mis", {31'h0, load_misaligned_exxeption}, 32'd1);
    chk("lw_wr0", {31'h0, ld_wr_reg}, 32'd0);
    step(); #1;
    chk("lw_wr1", {31'h0, ld_wr_reg}, 32'd1);
    chk("lw_rd", {27'h0, ld_wr_regindex}, 32'd5);
    chk("lw_wdata", ld_wr_wdata, 32'h6655_4433);
    chk("lw_stall_rd2", {31'h0, load_stall}, 32'd0);
    step(); #1;

    // LH 0x103 (crossing), then LHU 0x106 (aligned within word)
    req(3'b001, 32'h103, 5'd7);
    step(); noreq(); #1;
    chk("lh_stall", {31'h0, load_stall}, 32'd1);
    step(); req(3'b101, 32'h106, 5'd8); #1;
    chk("lh_wdata", ld_wr_wdata, 32'h0000_5544);
    chk("lh_rd", {27'h0, ld_wr_regindex}, 32'd7);
    step(); noreq(); #1;
    chk("lhu_wr", {31'h0, ld_wr_reg}, 32'd1);
    chk("lhu_wdata", ld_wr_wdata, 32'h0000_8877);
    chk("lhu_stall", {31'h0, load_stall}, 32'd0);
    step(); #1;

    // LH 0x106 sign extension, then aligned LW 0x104
    req(3'b001, 32'h106, 5'd9);
    step(); req(3'b010, 32'h104, 5'd10); #1;
    chk("lhs_wdata", ld_wr_wdata, 32'hFFFF_8877);
    step(); noreq(); #1;
    chk("lwa_wdata", ld_wr_wdata, 32'h8877_6655);
    chk("lwa_stall", {31'h0, load_stall}, 32'd0);
    step(); #1;

    // LW 0xFFFFFFFE wraps second read to address 0
    req(3'b010, 32'hFFFF_FFFE, 5'd11); #1;
    chk("wrap_raddr1", dsram_raddr, 32'hFFFF_FFFC);
    step(); noreq(); #1;
    chk("wrap_raddr2", dsram_raddr, 32'h0000_0000);
    step(); #1;
    chk("wrap_wdata", ld_wr_wdata, 32'h0100_DDCC);
    step(); #1;

    // LW 0x101 killed in RD2
    req(3'b010, 32'h101, 5'd12);
    step(); noreq(); #1;
    chk("kill_rd1_stall", {31'h0, load_stall}, 32'd1);
    step(); ld_kill = 1'b1; #1;
    chk("kill_wr", {31'h0, ld_wr_reg}, 32'd0);
    chk("kill_rcs", {31'h0, dsram_rcs}, 32'd0);
    step(); ld_kill = 1'b0; #1;
    chk("kill_idle_wr", {31'h0, ld_wr_reg}, 32'd0);
    chk("kill_idle_stall", {31'h0, load_stall}, 32'd0);

    // Kill blocks acceptance of a concurrent request
    req(3'b010, 32'h100, 5'd13); ld_kill = 1'b1; #1;
    chk("kill_req_rcs", {31'h0, dsram_rcs}, 32'd0);
    step(); noreq(); ld_kill = 1'b0; #1;
    chk("kill_req_nowr", {31'h0, ld_wr_reg}, 32'd0);

    // Reset during RD1 of crossing LW 0x101
    req(3'b010, 32'h101, 5'd14);
    step(); noreq(); cpurst = 1'b1; #1;
    chk("rrd1_rcs", {31'h0, dsram_rcs}, 32'd0);
    chk("rrd1_stall", {31'h0, load_stall}, 32'd0);
    chk("rrd1_mis", {31'h0, load_misaligned_exxeption}, 32'd0);
    step(); cpurst = 1'b0; #1;
    chk("rrel_wr", {31'h0, ld_wr_reg}, 32'd0);
    chk("rrel_wdata", ld_wr_wdata, 32'h0);
    chk("rrel_rdidx", {27'h0, ld_wr_regindex}, 32'd0);
    chk("rrel_rcs", {31'h0, dsram_rcs}, 32'd0);
    step(); #1;
    chk("rrel_wr2", {31'h0, ld_wr_reg}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
